// File: rtl/li_expander_pkg.sv
// Shared constants for the load-immediate expander: MIPS opcodes, out_kind codes,
// FSM state encodings and the I-type instruction packer.
package li_pkg;

    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        KIND_ADDIU = 2'd0,
        KIND_ORI   = 2'd1,
        KIND_LUI   = 2'd2,
        KIND_ORI2  = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LAST  = 2'd1,
        ST_FIRST = 2'd2
    } state_e;

    function automatic logic [31:0] enc_itype(input logic [5:0] opc, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/li_expander_if.sv
// Request and instruction-output channels of the load-immediate expander.
// The slave modport is the expander's view; master is the loader/memory side.
interface li_expander_if;

    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rt;
    logic [31:0] in_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic [1:0]  out_kind;

    modport slave (
        input  in_valid, in_rt, in_value, out_ready,
        output in_ready, out_valid, out_instr, out_last, out_kind
    );

    modport master (
        output in_valid, in_rt, in_value, out_ready,
        input  in_ready, out_valid, out_instr, out_last, out_kind
    );

endinterface

// File: rtl/li_expander_classify.sv
// li_classify: combinational split of a 32-bit constant into one instruction
// (addiu/ori/lui) or a lui+ori pair.
module li_classify
    import li_pkg::*;
#(
    parameter bit USE_ADDIU = 1'b1
) (
    input  logic [31:0] value,
    input  logic [4:0]  rt,
    output logic [31:0] first_instr,
    output kind_e       first_kind,
    output logic        is_pair,
    output logic [31:0] second_instr
);

    logic [15:0] hi;
    logic [15:0] lo;
    logic        fits_s16;

    assign hi = value[31:16];
    assign lo = value[15:0];
    // Sign-extending lo reproduces the value exactly when bits 31..15 agree.
    assign fits_s16 = (value[31:15] == '0) || (value[31:15] == '1);

    always_comb begin
        first_instr  = enc_itype(OPC_LUI, 5'd0, rt, hi);
        first_kind   = KIND_LUI;
        is_pair      = 1'b0;
        second_instr = enc_itype(OPC_ORI, rt, rt, lo);
        if (USE_ADDIU && fits_s16) begin
            first_instr = enc_itype(OPC_ADDIU, 5'd0, rt, lo);
            first_kind  = KIND_ADDIU;
        end else if (hi == 16'h0000) begin
            first_instr = enc_itype(OPC_ORI, 5'd0, rt, lo);
            first_kind  = KIND_ORI;
        end else if (lo != 16'h0000) begin
            is_pair = 1'b1;
        end
    end

endmodule

// File: rtl/li_expander.sv
// li_expander: turns {rt, 32-bit constant} requests into a stream of MIPS I-type
// instructions. Optional request/pair counters are enabled with LI_STATS_EN.
module li_expander
    import li_pkg::*;
#(
    parameter bit          USE_ADDIU = 1'b1,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    li_expander_if.slave     bus
`ifdef LI_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_req,
    output logic [CNT_W-1:0] stat_pair
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("li_expander: CNT_W must be at least 1");
    end

    state_e      state_q, state_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_last_q, out_last_d;
    kind_e       out_kind_q, out_kind_d;
    logic [31:0] pend_instr_q, pend_instr_d;

    logic [31:0] cls_first_instr;
    kind_e       cls_first_kind;
    logic        cls_is_pair;
    logic [31:0] cls_second_instr;
    logic        accept;

    li_classify #(.USE_ADDIU(USE_ADDIU)) u_classify (
        .value        (bus.in_value),
        .rt           (bus.in_rt),
        .first_instr  (cls_first_instr),
        .first_kind   (cls_first_kind),
        .is_pair      (cls_is_pair),
        .second_instr (cls_second_instr)
    );

    assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_LAST) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q != ST_IDLE);
    assign bus.out_instr = out_instr_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_kind  = out_kind_q;

    always_comb begin
        state_d      = state_q;
        out_instr_d  = out_instr_q;
        out_last_d   = out_last_q;
        out_kind_d   = out_kind_q;
        pend_instr_d = pend_instr_q;
        case (state_q)
            ST_FIRST: begin
                // The pair's ori goes out next; no new request may slip in between.
                if (bus.out_ready) begin
                    state_d     = ST_LAST;
                    out_instr_d = pend_instr_q;
                    out_last_d  = 1'b1;
                    out_kind_d  = KIND_ORI2;
                end
            end
            ST_LAST: begin
                if (bus.out_ready && !accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        if (accept) begin
            state_d      = cls_is_pair ? ST_FIRST : ST_LAST;
            out_instr_d  = cls_first_instr;
            out_last_d   = !cls_is_pair;
            out_kind_d   = cls_first_kind;
            pend_instr_d = cls_second_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            out_instr_q  <= '0;
            out_last_q   <= 1'b0;
            out_kind_q   <= KIND_ADDIU;
            pend_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            out_instr_q  <= out_instr_d;
            out_last_q   <= out_last_d;
            out_kind_q   <= out_kind_d;
            pend_instr_q <= pend_instr_d;
        end
    end

`ifdef LI_STATS_EN
    logic [CNT_W-1:0] stat_req_q, stat_req_d;
    logic [CNT_W-1:0] stat_pair_q, stat_pair_d;

    always_comb begin
        stat_req_d  = stat_req_q;
        stat_pair_d = stat_pair_q;
        if (accept) begin
            stat_req_d = stat_req_q + 1'b1;
            if (cls_is_pair) begin
                stat_pair_d = stat_pair_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_req_q  <= '0;
            stat_pair_q <= '0;
        end else begin
            stat_req_q  <= stat_req_d;
            stat_pair_q <= stat_pair_d;
        end
    end

    assign stat_req  = stat_req_q;
    assign stat_pair = stat_pair_q;
`endif

endmodule

// File: tb/tb_li_expander.sv
// Scoreboard bench for li_expander: directed cases for each instruction form,
// back-pressure, reset mid-pair and back-to-back issue, then a random mix.
module tb_li_expander;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
        logic [1:0]  kind;
    } beat_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    int   hs_cyc;
    int   hs_prev;
    bit   rnd_rdy;
    beat_t sb[$];

    li_expander_if li();

`ifdef LI_STATS_EN
    logic [31:0] stat_req;
    logic [31:0] stat_pair;
`endif

    li_expander #(.USE_ADDIU(1'b1), .CNT_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (li)
`ifdef LI_STATS_EN
        ,
        .stat_req  (stat_req),
        .stat_pair (stat_pair)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void push_beat(input logic [31:0] instr, input logic last, input logic [1:0] kind);
        beat_t b;
        b.instr = instr;
        b.last  = last;
        b.kind  = kind;
        sb.push_back(b);
    endfunction

    // Reference expansion straight from the instruction formats.
    function automatic void push_model(input logic [4:0] rt, input logic [31:0] v);
        logic [16:0] top;
        top = v[31:15];
        if (top == 17'h00000 || top == 17'h1FFFF)
            push_beat({6'h09, 5'd0, rt, v[15:0]}, 1'b1, 2'd0);
        else if (v[31:16] == 16'h0000)
            push_beat({6'h0D, 5'd0, rt, v[15:0]}, 1'b1, 2'd1);
        else if (v[15:0] == 16'h0000)
            push_beat({6'h0F, 5'd0, rt, v[31:16]}, 1'b1, 2'd2);
        else begin
            push_beat({6'h0F, 5'd0, rt, v[31:16]}, 1'b0, 2'd2);
            push_beat({6'h0D, rt, rt, v[15:0]}, 1'b1, 2'd3);
        end
    endfunction

    // Output monitor: every handshaken beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && li.out_valid && li.out_ready) begin
            hs_prev = hs_cyc;
            hs_cyc  = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_beat", li.out_instr, 32'h0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("instr", li.out_instr, e.instr);
                chk("last", {31'd0, li.out_last}, {31'd0, e.last});
                chk("kind", {30'd0, li.out_kind}, {30'd0, e.kind});
            end
        end
    end

    task automatic send(input logic [4:0] rt, input logic [31:0] v);
        bit done;
        done = 1'b0;
        li.in_valid = 1'b1;
        li.in_rt    = rt;
        li.in_value = v;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (li.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            if (rnd_rdy) li.out_ready = ($urandom_range(0, 3) != 0);
        end
        li.in_valid = 1'b0;
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (rnd_rdy) li.out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        logic [31:0] v;
        checks = 0;
        errors = 0;
        cyc = 0;
        hs_cyc = 0;
        hs_prev = 0;
        rnd_rdy = 1'b0;
        reset = 1'b1;
        li.in_valid = 1'b0;
        li.in_rt = 5'd0;
        li.in_value = 32'd0;
        li.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", {31'd0, li.out_valid}, 32'd0);
        chk("rst_out_instr", li.out_instr, 32'd0);
        chk("rst_out_last", {31'd0, li.out_last}, 32'd0);
        chk("rst_out_kind", {30'd0, li.out_kind}, 32'd0);
        chk("rst_in_ready", {31'd0, li.in_ready}, 32'd1);
`ifdef LI_STATS_EN
        chk("rst_stat_req", stat_req, 32'd0);
`endif
        @(posedge clk);
        #1 li.out_ready = 1'b1;

        push_beat(32'h2408_FFFE, 1'b1, 2'd0);
        send(5'd8, 32'hFFFF_FFFE);
        push_beat(32'h3409_8000, 1'b1, 2'd1);
        send(5'd9, 32'h0000_8000);
        push_beat(32'h3C0A_1234, 1'b1, 2'd2);
        send(5'd10, 32'h1234_0000);
        idle(3);
        chk("t123_drained", 32'(sb.size()), 32'd0);

        // Pair under back-pressure.
        li.out_ready = 1'b0;
        push_beat(32'h3C04_1234, 1'b0, 2'd2);
        push_beat(32'h3484_5678, 1'b1, 2'd3);
        send(5'd4, 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'd0, li.out_valid}, 32'd1);
            chk("t4_hold_instr", li.out_instr, 32'h3C04_1234);
            chk("t4_hold_last", {31'd0, li.out_last}, 32'd0);
            chk("t4_in_ready_blocked", {31'd0, li.in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        li.out_ready = 1'b1;
        @(negedge clk);
        chk("t4_in_ready_first", {31'd0, li.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t4_second_instr", li.out_instr, 32'h3484_5678);
        chk("t4_in_ready_second", {31'd0, li.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("t4_drained", 32'(sb.size()), 32'd0);

        // Reset between the lui and ori beats of a pair.
        li.out_ready = 1'b0;
        push_beat(32'h3C04_1234, 1'b0, 2'd2);
        send(5'd4, 32'h1234_5678);
        li.out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        li.out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_out_valid", {31'd0, li.out_valid}, 32'd0);
        chk("t5_in_ready", {31'd0, li.in_ready}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        li.out_ready = 1'b1;
        idle(4);
        chk("t5_no_ori", 32'(sb.size()), 32'd0);

        // Back-to-back singles.
        push_beat(32'h2402_0007, 1'b1, 2'd0);
        push_beat(32'h2403_0009, 1'b1, 2'd0);
        send(5'd2, 32'h0000_0007);
        send(5'd3, 32'h0000_0009);
        idle(2);
        chk("t6_no_bubble", 32'(hs_cyc - hs_prev), 32'd1);
        chk("t6_drained", 32'(sb.size()), 32'd0);
`ifdef LI_STATS_EN
        chk("t6_stat_req", stat_req, 32'd2);
        chk("t6_stat_pair", stat_pair, 32'd0);
`endif

        // Random mix of all forms with random back-pressure.
        rnd_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [4:0] rt;
            rt = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0: v = {{16{1'($urandom_range(0, 1))}}, 16'($urandom)};
                1: v = {16'h0000, 16'($urandom)};
                2: v = {16'($urandom), 16'h0000};
                3: v = 32'h0000_0000;
                default: v = $urandom;
            endcase
            push_model(rt, v);
            send(rt, v);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_rdy = 1'b0;
        li.out_ready = 1'b1;
        for (int i = 0; i < 500 && sb.size() != 0; i++) idle(1);
        idle(2);
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
